// File: rtl/ram_write_drain_2w.sv
// ram_write_drain_2w
//   Writer-side companion for a two-write-port synchronous RAM. It buffers
//   single-beat write requests in an in-order queue. It drains up to two of
//   them per cycle onto the RAM write ports: port 1 carries the older entry and
//   port 2 the newer one. After reset it first sweeps zeros into every RAM entry.
//
// Optional feature: define RAM_WQ_FWD_EN to add a write-forwarding search
//   (fwd_addr / fwd_hit / fwd_data) over the entries still in the queue.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     producer handshake for one write request
//   in_addr, in_data      request address / data
//   drain_stall           suppress RAM writes this cycle (ignored during init sweep)
//   waddr1/wdata1/we1     RAM write port 1 (older entry)
//   waddr2/wdata2/we2     RAM write port 2 (newer entry)
//   init_done             init sweep finished, queue is operating
//   queue_empty           no pending writes
//   queue_count           number of pending writes
//   fwd_addr/fwd_hit/fwd_data   (RAM_WQ_FWD_EN only) newest pending write to fwd_addr
module ram_write_drain_2w #(
   parameter int BRAM_ADDR_WIDTH = 5,
   parameter int BRAM_DATA_WIDTH = 32,
   parameter int DATA_DEPTH      = 32,
   parameter int QUEUE_DEPTH     = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [BRAM_ADDR_WIDTH-1:0]       in_addr,
   input  logic [BRAM_DATA_WIDTH-1:0]       in_data,
   input  logic                             drain_stall,
   output logic [BRAM_ADDR_WIDTH-1:0]       waddr1,
   output logic [BRAM_DATA_WIDTH-1:0]       wdata1,
   output logic                             we1,
   output logic [BRAM_ADDR_WIDTH-1:0]       waddr2,
   output logic [BRAM_DATA_WIDTH-1:0]       wdata2,
   output logic                             we2,
   output logic                             init_done,
   output logic                             queue_empty,
   output logic [$clog2(QUEUE_DEPTH):0]     queue_count
`ifdef RAM_WQ_FWD_EN
   ,
   input  logic [BRAM_ADDR_WIDTH-1:0]       fwd_addr,
   output logic                             fwd_hit,
   output logic [BRAM_DATA_WIDTH-1:0]       fwd_data
`endif
);

   localparam int AW = BRAM_ADDR_WIDTH;
   localparam int DW = BRAM_DATA_WIDTH;
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] LAST_PAIR = AW'(DATA_DEPTH - 2);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   init_ptr_q, init_ptr_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   // Queue payload storage; only the pointers and count need reset.
   logic [AW-1:0]   mem_addr_q [QUEUE_DEPTH];
   logic [AW-1:0]   mem_addr_d [QUEUE_DEPTH];
   logic [DW-1:0]   mem_data_q [QUEUE_DEPTH];
   logic [DW-1:0]   mem_data_d [QUEUE_DEPTH];

   logic [PW-1:0]   head_p1;
   logic            push;
   logic [1:0]      pops;

   assign head_p1 = head_q + PW'(1);

   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      push       = 1'b0;
      pops       = 2'd0;
      in_ready   = 1'b0;
      we1        = 1'b0;
      we2        = 1'b0;
      waddr1     = mem_addr_q[head_q];
      wdata1     = mem_data_q[head_q];
      waddr2     = mem_addr_q[head_p1];
      wdata2     = mem_data_q[head_p1];

      if (!reset) begin
         case (state_q)
            ST_INIT: begin
               // Zero two consecutive RAM entries per cycle.
               we1        = 1'b1;
               we2        = 1'b1;
               waddr1     = init_ptr_q;
               waddr2     = init_ptr_q + AW'(1);
               wdata1     = '0;
               wdata2     = '0;
               init_ptr_d = init_ptr_q + AW'(2);
               if (init_ptr_q == LAST_PAIR) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               // Ready depends only on the registered count, so a drain in the
               // same cycle does not open a slot early.
               in_ready = (count_q < CW'(QUEUE_DEPTH));
               push     = in_valid & in_ready;
               if (!drain_stall && count_q >= CW'(1)) begin
                  we1 = 1'b1;
               end
               if (!drain_stall && count_q >= CW'(2)) begin
                  we2 = 1'b1;
               end
               pops   = {1'b0, we1} + {1'b0, we2};
               head_d = head_q + PW'(pops);
               if (push) begin
                  mem_addr_d[tail_q] = in_addr;
                  mem_data_d[tail_q] = in_data;
                  tail_d             = tail_q + PW'(1);
               end
               count_d = count_q + CW'(push) - CW'(pops);
            end
            default: begin
               state_d = ST_INIT;
            end
         endcase
      end
   end

   assign init_done   = !reset && (state_q == ST_RUN);
   assign queue_empty = (count_q == '0);
   assign queue_count = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

`ifdef RAM_WQ_FWD_EN
   // Walk from oldest to newest so the newest matching entry wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (!reset && state_q == ST_RUN) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_addr_q[idx] == fwd_addr)) begin
               fwd_hit  = 1'b1;
               fwd_data = mem_data_q[idx];
            end
         end
      end
   end
`endif

endmodule
